// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters. The winner's operands
// and control code are latched, held on the ALU for ALU_LAT cycles, and the
// sampled result/zero is returned with a one-cycle response strobe.
module alu_share_arbiter #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CTRL_W  = 4,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic                clk_i,
   input  logic                rst_n,
   input  logic [1:0]          req_valid_i,
   output logic [1:0]          req_ready_o,
   input  logic [2*DATA_W-1:0] src1_i,
   input  logic [2*DATA_W-1:0] src2_i,
   input  logic [2*CTRL_W-1:0] ctrl_i,
   output logic [DATA_W-1:0]   alu_src1_o,
   output logic [DATA_W-1:0]   alu_src2_o,
   output logic [CTRL_W-1:0]   alu_ctrl_o,
   input  logic [DATA_W-1:0]   alu_result_i,
   input  logic                alu_zero_i,
   output logic [1:0]          rsp_valid_o,
   output logic [DATA_W-1:0]   result_o,
   output logic                zero_o,
   output logic                busy_o
);

   // Counter must be at least one bit wide even when ALU_LAT is 1.
   localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e          state_q;
   logic            gnt_q;
   logic            last_grant_q;
   logic [CntW-1:0] cnt_q;
   logic            win;
   logic            any_valid;

   // Round-robin pick: a lone request wins; on a tie the one not served last wins.
   always_comb begin
      win = 1'b0;
      case (req_valid_i)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = ~last_grant_q;
         default: win = 1'b0;
      endcase
   end

   assign any_valid   = |req_valid_i;
   assign req_ready_o = (state_q == StIdle && any_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign busy_o      = (state_q != StIdle);

   // Arbitration FSM: accept, hold operands on the ALU, capture, respond.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         alu_src1_o   <= '0;
         alu_src2_o   <= '0;
         alu_ctrl_o   <= '0;
         result_o     <= '0;
         zero_o       <= 1'b0;
         rsp_valid_o  <= 2'b00;
      end else begin
         case (state_q)
            StIdle: begin
               rsp_valid_o <= 2'b00;
               if (any_valid) begin
                  alu_src1_o   <= win ? src1_i[DATA_W +: DATA_W] : src1_i[0 +: DATA_W];
                  alu_src2_o   <= win ? src2_i[DATA_W +: DATA_W] : src2_i[0 +: DATA_W];
                  alu_ctrl_o   <= win ? ctrl_i[CTRL_W +: CTRL_W] : ctrl_i[0 +: CTRL_W];
                  gnt_q        <= win;
                  last_grant_q <= win;
                  cnt_q        <= CntW'(ALU_LAT - 1);
                  state_q      <= StExec;
               end
            end
            StExec: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else begin
                  result_o    <= alu_result_i;
                  zero_o      <= alu_zero_i;
                  rsp_valid_o <= gnt_q ? 2'b10 : 2'b01;
                  state_q     <= StResp;
               end
            end
            StResp: begin
               rsp_valid_o <= 2'b00;
               state_q     <= StIdle;
            end
            default: begin
               rsp_valid_o <= 2'b00;
               state_q     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of grants and results.
module tb_alu_share_arbiter;

   logic clk;
   logic rst_n;

   // Instance A: ALU_LAT = 1
   logic [1:0]  valid_a, ready_a, rsp_a;
   logic [63:0] src1_a, src2_a;
   logic [7:0]  ctrl_a;
   logic [31:0] alu_s1_a, alu_s2_a, alu_res_a, result_a;
   logic [3:0]  alu_ctrl_a;
   logic        alu_zero_a, zero_a, busy_a;

   // Instance B: ALU_LAT = 3
   logic [1:0]  valid_b, ready_b, rsp_b;
   logic [63:0] src1_b, src2_b;
   logic [7:0]  ctrl_b;
   logic [31:0] alu_s1_b, alu_s2_b, alu_res_b, result_b;
   logic [3:0]  alu_ctrl_b;
   logic        alu_zero_b, zero_b, busy_b;

   int n_checks = 0;
   int n_errors = 0;
   logic m_last;

   function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      case (c)
         4'd4:    return a + b;
         4'd5:    return a - b;
         4'd6:    return {31'b0, ($signed(a) < $signed(b))};
         default: return a ^ b;
      endcase
   endfunction

   alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .ALU_LAT(1)) dut_a (
      .clk_i(clk), .rst_n(rst_n), .req_valid_i(valid_a), .req_ready_o(ready_a),
      .src1_i(src1_a), .src2_i(src2_a), .ctrl_i(ctrl_a),
      .alu_src1_o(alu_s1_a), .alu_src2_o(alu_s2_a), .alu_ctrl_o(alu_ctrl_a),
      .alu_result_i(alu_res_a), .alu_zero_i(alu_zero_a), .rsp_valid_o(rsp_a),
      .result_o(result_a), .zero_o(zero_a), .busy_o(busy_a)
   );

   alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .ALU_LAT(3)) dut_b (
      .clk_i(clk), .rst_n(rst_n), .req_valid_i(valid_b), .req_ready_o(ready_b),
      .src1_i(src1_b), .src2_i(src2_b), .ctrl_i(ctrl_b),
      .alu_src1_o(alu_s1_b), .alu_src2_o(alu_s2_b), .alu_ctrl_o(alu_ctrl_b),
      .alu_result_i(alu_res_b), .alu_zero_i(alu_zero_b), .rsp_valid_o(rsp_b),
      .result_o(result_b), .zero_o(zero_b), .busy_o(busy_b)
   );

   // Behavioural ALUs driven by each arbiter's registered outputs.
   always_comb begin
      alu_res_a  = alu_ref(alu_ctrl_a, alu_s1_a, alu_s2_a);
      alu_zero_a = (alu_res_a == 32'd0);
      alu_res_b  = alu_ref(alu_ctrl_b, alu_s1_b, alu_s2_b);
      alu_zero_b = (alu_res_b == 32'd0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rand_ctrl();
      logic [3:0] c0, c1;
      logic [3:0] tbl [4];
      tbl[0] = 4'd4; tbl[1] = 4'd5; tbl[2] = 4'd6; tbl[3] = 4'($urandom());
      c0 = tbl[$urandom_range(0, 3)];
      c1 = tbl[$urandom_range(0, 3)];
      return {c1, c0};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      valid_a = 2'b00; valid_b = 2'b00;
      #1;
      check("rst_alu_src1", alu_s1_a, 0);
      check("rst_result", result_a, 0);
      check("rst_rsp", rsp_a, 0);
      check("rst_busy", busy_a, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_last = 1'b1;
   endtask

   // One full transaction on instance A, starting at the beginning of an idle cycle.
   // churn_v is what the requesters present while the operation is in flight.
   task automatic run_op(input logic [1:0] v, input logic [63:0] s1, input logic [63:0] s2,
                         input logic [7:0] c, input logic [1:0] churn_v);
      logic g;
      logic [31:0] a, b, r;
      logic [3:0] cc;
      check("idle_rsp", rsp_a, 0);
      check("idle_busy", busy_a, 0);
      valid_a = v; src1_a = s1; src2_a = s2; ctrl_a = c;
      #1;
      if (v == 2'b00) begin
         check("ready_none", ready_a, 0);
         next();
         return;
      end
      g = (v == 2'b01) ? 1'b0 : (v == 2'b10) ? 1'b1 : !m_last;
      check("grant", ready_a, g ? 2'b10 : 2'b01);
      a  = g ? s1[63:32] : s1[31:0];
      b  = g ? s2[63:32] : s2[31:0];
      cc = g ? c[7:4] : c[3:0];
      r  = alu_ref(cc, a, b);
      m_last = g;
      next();
      // Execute cycle: churn every input; latched values must not move.
      valid_a = churn_v; src1_a = {$urandom(), $urandom()}; src2_a = {$urandom(), $urandom()};
      ctrl_a = 8'($urandom());
      #1;
      check("exec_src1", alu_s1_a, a);
      check("exec_src2", alu_s2_a, b);
      check("exec_ctrl", alu_ctrl_a, cc);
      check("exec_busy", busy_a, 1);
      check("exec_ready", ready_a, 0);
      check("exec_rsp", rsp_a, 0);
      next();
      #1;
      check("resp_ready", ready_a, 0);
      check("resp_valid", rsp_a, g ? 2'b10 : 2'b01);
      check("resp_result", result_a, r);
      check("resp_zero", zero_a, (r == 32'd0));
      check("resp_busy", busy_a, 1);
      next();
   endtask

   initial begin
      valid_a = 0; src1_a = 0; src2_a = 0; ctrl_a = 0;
      valid_b = 0; src1_b = 0; src2_b = 0; ctrl_b = 0;
      m_last = 1'b1;
      do_reset();

      // Single request: 5 + 7
      run_op(2'b01, {32'd0, 32'd5}, {32'd0, 32'd7}, {4'd0, 4'd4}, 2'b00);
      check("t1_result_held", result_a, 12);

      // Simultaneous requests after reset: req0 SUBU 9-9, req1 ADDU 1+2
      do_reset();
      run_op(2'b11, {32'd1, 32'd9}, {32'd2, 32'd9}, {4'd4, 4'd5}, 2'b10);
      run_op(2'b10, {32'd1, 32'd9}, {32'd2, 32'd9}, {4'd4, 4'd5}, 2'b00);
      run_op(2'b11, {$urandom(), $urandom()}, {$urandom(), $urandom()}, rand_ctrl(), 2'b00);

      // Fairness: both held valid for 8 back-to-back ops
      for (int i = 0; i < 8; i++) begin
         run_op(2'b11, {$urandom(), $urandom()}, {$urandom(), $urandom()}, rand_ctrl(), 2'b11);
      end

      // Input churn with valid dropped mid-operation
      run_op(2'b01, {$urandom(), $urandom()}, {$urandom(), $urandom()}, rand_ctrl(), 2'b00);
      run_op(2'b10, {$urandom(), $urandom()}, {$urandom(), $urandom()}, rand_ctrl(), 2'b00);

      // ALU_LAT = 3 on instance B: req1 SLT 0xFFFFFFFF < 1
      valid_b = 2'b10; src1_b = {32'hFFFF_FFFF, 32'd0}; src2_b = {32'd1, 32'd0};
      ctrl_b = {4'd6, 4'd0};
      #1;
      check("lat3_grant", ready_b, 2'b10);
      next();
      for (int k = 1; k <= 3; k++) begin
         valid_b = 2'($urandom()); src1_b = {$urandom(), $urandom()}; ctrl_b = 8'($urandom());
         #1;
         check("lat3_src1", alu_s1_b, 32'hFFFF_FFFF);
         check("lat3_src2", alu_s2_b, 1);
         check("lat3_ctrl", alu_ctrl_b, 6);
         check("lat3_rsp_early", rsp_b, 0);
         check("lat3_busy", busy_b, 1);
         next();
      end
      valid_b = 2'b00;
      #1;
      check("lat3_rsp", rsp_b, 2'b10);
      check("lat3_result", result_b, 1);
      check("lat3_zero", zero_b, 0);
      next();
      check("lat3_idle", busy_b, 0);
      check("lat3_rsp_clear", rsp_b, 0);

      // Reset mid-operation: req0 accepted, reset during execute
      valid_a = 2'b01; src1_a = {32'd0, 32'd3}; src2_a = {32'd0, 32'd4}; ctrl_a = 8'h04;
      #1;
      check("t5_grant", ready_a, 2'b01);
      m_last = 1'b0;
      next();
      valid_a = 2'b00;
      rst_n = 1'b0;
      #1;
      check("t5_src1", alu_s1_a, 0);
      check("t5_src2", alu_s2_a, 0);
      check("t5_ctrl", alu_ctrl_a, 0);
      check("t5_result", result_a, 0);
      check("t5_zero", zero_a, 0);
      check("t5_rsp", rsp_a, 0);
      check("t5_busy", busy_a, 0);
      check("t5_ready", ready_a, 0);
      next();
      rst_n = 1'b1;
      m_last = 1'b1;
      next();
      check("t5_no_late_rsp", rsp_a, 0);
      run_op(2'b11, {$urandom(), $urandom()}, {$urandom(), $urandom()}, rand_ctrl(), 2'b11);

      // Randomized traffic
      for (int i = 0; i < 24; i++) begin
         run_op(2'($urandom()), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                rand_ctrl(), 2'($urandom()));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
